// File: rtl/riscv_test_pkg.sv
// Shared encodings for the riscv-tests tohost monitor: FSM states, result codes
// and the tohost write-data decode.
package riscv_test_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_PASS    = 2'd1;
    localparam logic [1:0] RES_FAIL    = 2'd2;
    localparam logic [1:0] RES_TIMEOUT = 2'd3;

    localparam logic [31:0] TOHOST_PASS         = 32'h1;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

    // Zero is the test-env clear; even nonzero values are syscall proxy requests.
    function automatic logic [1:0] decode_tohost(input logic [31:0] wdata);
        if (wdata == '0)          return RES_NONE;
        if (wdata == TOHOST_PASS) return RES_PASS;
        if (wdata[0])             return RES_FAIL;
        return RES_NONE;
    endfunction

endpackage

// File: rtl/riscv_test_monitor_counter.sv
// 32-bit event counter with enable, freeze and synchronous active-low clear.
module monitor_counter (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        en,
    input  logic        freeze,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!clear_n)
            count <= '0;
        else if (en && !freeze)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// Passive tohost observer: registered pass/fail/timeout verdict, cycle and
// retire counters, and a finish request after a drain period.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned DRAIN_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    input  logic        retire,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] fail_testnum,
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count,
    output logic        finish
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST   = (DRAIN_CYCLES == 0) ? '0 : 32'(DRAIN_CYCLES - 1);

    state_t      state, state_next;
    logic [31:0] drain_cnt, drain_cnt_next;
    logic        done_next, pass_next, fail_next, timeout_next, finish_next;
    logic [30:0] testnum_next;
    logic        in_run, hit;
    logic [1:0]  hit_res, verdict;

    assign in_run  = (state == ST_RUN);
    assign hit     = in_run && mem_we && (mem_addr == TOHOST_ADDR) && (mem_be == 4'hF);
    assign hit_res = hit ? decode_tohost(mem_wdata) : RES_NONE;

    // Counters keep counting through the verdict cycle and freeze once RUN is left.
    monitor_counter u_cycle_counter (
        .clk     (clk),
        .clear_n (rst),
        .en      (1'b1),
        .freeze  (!in_run),
        .count   (cycle_count)
    );

    monitor_counter u_retire_counter (
        .clk     (clk),
        .clear_n (rst),
        .en      (retire),
        .freeze  (!in_run),
        .count   (retire_count)
    );

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        done_next      = done;
        pass_next      = pass;
        fail_next      = fail;
        timeout_next   = timeout;
        finish_next    = finish;
        testnum_next   = fail_testnum;
        verdict        = RES_NONE;

        case (state)
            ST_RUN: begin
                // A real hit on the last cycle takes priority over the timeout.
                if (hit_res != RES_NONE)
                    verdict = hit_res;
                else if (cycle_count == TIMEOUT_LAST)
                    verdict = RES_TIMEOUT;

                if (verdict != RES_NONE) begin
                    done_next      = 1'b1;
                    pass_next      = (verdict == RES_PASS);
                    fail_next      = (verdict == RES_FAIL);
                    timeout_next   = (verdict == RES_TIMEOUT);
                    drain_cnt_next = '0;
                    if (verdict == RES_FAIL)
                        testnum_next = mem_wdata[31:1];
                    if (DRAIN_CYCLES == 0) begin
                        finish_next = 1'b1;
                        state_next  = ST_HALT;
                    end else begin
                        state_next  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    finish_next = 1'b1;
                    state_next  = ST_HALT;
                end else begin
                    drain_cnt_next = drain_cnt + 32'd1;
                end
            end
            ST_HALT: ;
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_RUN;
            drain_cnt    <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            finish       <= 1'b0;
            fail_testnum <= '0;
        end else begin
            state        <= state_next;
            drain_cnt    <= drain_cnt_next;
            done         <= done_next;
            pass         <= pass_next;
            fail         <= fail_next;
            timeout      <= timeout_next;
            finish       <= finish_next;
            fail_testnum <= testnum_next;
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed scoreboard bench for riscv_test_monitor: one instance with a short
// timeout and 4-cycle drain, one with zero drain.
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst_a, rst_c;
    logic        mem_we, retire;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        done_a, pass_a, fail_a, timeout_a, finish_a;
    logic [30:0] testnum_a;
    logic [31:0] cycle_a, retire_a;
    logic        done_c, pass_c, fail_c, timeout_c, finish_c;
    logic [30:0] testnum_c;
    logic [31:0] cycle_c, retire_c;

    int unsigned checks = 0;
    int unsigned passes = 0;

    always #5 clk = ~clk;

    riscv_test_monitor #(
        .TOHOST_ADDR    (32'h0000_1000),
        .TIMEOUT_CYCLES (20),
        .DRAIN_CYCLES   (4)
    ) dut_a (
        .clk (clk), .rst (rst_a), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_be (mem_be), .retire (retire),
        .done (done_a), .pass (pass_a), .fail (fail_a), .timeout (timeout_a),
        .fail_testnum (testnum_a), .cycle_count (cycle_a),
        .retire_count (retire_a), .finish (finish_a)
    );

    riscv_test_monitor #(
        .TOHOST_ADDR    (32'h0000_1000),
        .TIMEOUT_CYCLES (20),
        .DRAIN_CYCLES   (0)
    ) dut_c (
        .clk (clk), .rst (rst_c), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_be (mem_be), .retire (retire),
        .done (done_c), .pass (pass_c), .fail (fail_c), .timeout (timeout_c),
        .fail_testnum (testnum_c), .cycle_count (cycle_c),
        .retire_count (retire_c), .finish (finish_c)
    );

    typedef struct {
        logic        done, pass, fail, timeout, finish;
        logic [30:0] testnum;
        logic [31:0] cycles, retires;
    } obs_t;

    typedef struct {
        string       tag;
        logic        pass, fail, timeout;
        logic [30:0] testnum;
        logic [31:0] cycles, retires;
        int unsigned latency;
    } exp_t;

    exp_t sb[$];

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0) begin
            o.done = done_a; o.pass = pass_a; o.fail = fail_a; o.timeout = timeout_a;
            o.finish = finish_a; o.testnum = testnum_a; o.cycles = cycle_a; o.retires = retire_a;
        end else begin
            o.done = done_c; o.pass = pass_c; o.fail = fail_c; o.timeout = timeout_c;
            o.finish = finish_c; o.testnum = testnum_c; o.cycles = cycle_c; o.retires = retire_c;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0; retire = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        mem_we = 1'b1; mem_addr = addr; mem_wdata = data; mem_be = be;
    endtask

    task automatic push_exp(input string tag, input logic p, input logic f, input logic t,
                            input logic [30:0] tn, input logic [31:0] cyc,
                            input logic [31:0] ret, input int unsigned lat);
        exp_t e;
        e.tag = tag; e.pass = p; e.fail = f; e.timeout = t; e.testnum = tn;
        e.cycles = cyc; e.retires = ret; e.latency = lat;
        sb.push_back(e);
    endtask

    task automatic await_verdict(input int which, input int unsigned budget);
        int unsigned n = 0;
        exp_t e;
        obs_t o;
        while (sample(which).done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        o = sample(which);
        chk({e.tag, " done"},    32'(o.done),    32'd1);
        chk({e.tag, " pass"},    32'(o.pass),    32'(e.pass));
        chk({e.tag, " fail"},    32'(o.fail),    32'(e.fail));
        chk({e.tag, " timeout"}, 32'(o.timeout), 32'(e.timeout));
        chk({e.tag, " testnum"}, 32'(o.testnum), 32'(e.testnum));
        chk({e.tag, " cycles"},  o.cycles,       e.cycles);
        chk({e.tag, " retires"}, o.retires,      e.retires);
        chk({e.tag, " latency"}, n,              e.latency);
    endtask

    task automatic check_cleared(input string tag, input int which);
        obs_t o;
        o = sample(which);
        chk({tag, " done"},    32'(o.done),    32'd0);
        chk({tag, " pass"},    32'(o.pass),    32'd0);
        chk({tag, " fail"},    32'(o.fail),    32'd0);
        chk({tag, " timeout"}, 32'(o.timeout), 32'd0);
        chk({tag, " finish"},  32'(o.finish),  32'd0);
        chk({tag, " testnum"}, 32'(o.testnum), 32'd0);
        chk({tag, " cycles"},  o.cycles,       32'd0);
        chk({tag, " retires"}, o.retires,      32'd0);
    endtask

    task automatic await_finish(input string tag, input int unsigned expected);
        int unsigned n = 0;
        while (finish_a !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " drain"}, n, expected);
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_a = 1'b0;
        rst_c = 1'b0;
        tick();
        tick();
        check_cleared("reset_a", 0);
        check_cleared("reset_c", 1);

        // Basic pass: 10 cycles with 7 retires, retire also held on the hit cycle
        rst_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            retire = (i < 7);
            tick();
        end
        store(32'h0000_1000, 32'h1, 4'hF);
        retire = 1'b1;
        push_exp("pass11", 1'b1, 1'b0, 1'b0, 31'd0, 32'd11, 32'd8, 0);
        tick();
        idle();
        await_verdict(0, 5);
        await_finish("pass11", 4);
        chk("pass11 frozen cycles", cycle_a, 32'd11);
        chk("pass11 done sticky", 32'(done_a), 32'd1);

        // Reset in the middle of DRAIN, then a normal pass afterwards
        reset_a();
        tick();
        store(32'h0000_1000, 32'h1, 4'hF);
        push_exp("predrain", 1'b1, 1'b0, 1'b0, 31'd0, 32'd2, 32'd0, 0);
        tick();
        idle();
        await_verdict(0, 5);
        tick();
        tick();
        rst_a = 1'b0;
        tick();
        check_cleared("middrain", 0);
        rst_a = 1'b1;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        tick();
        tick();
        store(32'h0000_1000, 32'h1, 4'hF);
        push_exp("postreset", 1'b1, 1'b0, 1'b0, 31'd0, 32'd4, 32'd1, 0);
        tick();
        idle();
        await_verdict(0, 5);
        await_finish("postreset", 4);

        // Clear and syscall values ignored, odd value fails, later pass ignored
        reset_a();
        store(32'h0000_1000, 32'h0, 4'hF);
        tick();
        chk("clear ignored", 32'(done_a), 32'd0);
        store(32'h0000_1000, 32'h2, 4'hF);
        tick();
        chk("even ignored", 32'(done_a), 32'd0);
        store(32'h0000_1000, 32'h7, 4'hF);
        push_exp("fail3", 1'b0, 1'b1, 1'b0, 31'd3, 32'd3, 32'd0, 0);
        tick();
        idle();
        await_verdict(0, 5);
        store(32'h0000_1000, 32'h1, 4'hF);
        tick();
        idle();
        chk("late pass ignored", 32'(pass_a), 32'd0);
        chk("late fail held", 32'(fail_a), 32'd1);
        chk("late testnum held", 32'(testnum_a), 32'd3);
        chk("late cycles frozen", cycle_a, 32'd3);

        // Partial-byte, wrong-address and non-strobed stores ignored -> timeout
        reset_a();
        store(32'h0000_1000, 32'h1, 4'h1);
        tick();
        store(32'h0000_1004, 32'h1, 4'hF);
        tick();
        store(32'h0000_1000, 32'h1, 4'hF);
        mem_we = 1'b0;
        tick();
        idle();
        chk("ignored stores", 32'(done_a), 32'd0);
        push_exp("timeout20", 1'b0, 1'b0, 1'b1, 31'd0, 32'd20, 32'd0, 20 - 3);
        await_verdict(0, 30);

        // Hit on the timeout cycle wins, and its retire pulse is counted
        reset_a();
        for (int i = 0; i < 19; i++) tick();
        store(32'h0000_1000, 32'h1, 4'hF);
        retire = 1'b1;
        push_exp("hit19", 1'b1, 1'b0, 1'b0, 31'd0, 32'd20, 32'd1, 0);
        tick();
        idle();
        await_verdict(0, 5);

        // Zero drain: finish rises with done
        rst_c = 1'b1;
        tick();
        tick();
        store(32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
        push_exp("drain0", 1'b0, 1'b1, 1'b0, 31'h7FFF_FFFF, 32'd3, 32'd0, 0);
        tick();
        idle();
        await_verdict(1, 5);
        chk("drain0 finish", 32'(finish_c), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
